// File: rtl/dpram_arbiter_pkg.sv
// Shared types and constants for the dpram_arbiter port-sharing block.
package dpram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    CLEAR
  } state_t;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

endpackage

// File: rtl/dpram_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie, the requester not granted last time wins.
module rr_pick2
  import dpram_arbiter_pkg::*;
(
  input  logic req_0,
  input  logic req_1,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

  always_comb begin
    valid = req_0 | req_1;
    if (req_0 && req_1) begin
      grant = ~last_grant;
    end else if (req_1) begin
      grant = REQ_1;
    end else begin
      grant = REQ_0;
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares one dpram port between two req/ack requesters and a full-RAM clear engine.
module dpram_arbiter
  import dpram_arbiter_pkg::*;
#(
  parameter int unsigned address_width = 10,
  parameter int unsigned data_width    = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_0,
  input  logic                     req_1,
  input  logic                     wren_0,
  input  logic                     wren_1,
  input  logic [address_width-1:0] address_0,
  input  logic [address_width-1:0] address_1,
  input  logic [data_width-1:0]    wdata_0,
  input  logic [data_width-1:0]    wdata_1,
  output logic                     ack_0,
  output logic                     ack_1,
  output logic [data_width-1:0]    rdata,
  input  logic                     clear_start,
  input  logic [data_width-1:0]    clear_value,
  output logic                     clear_busy,
  output logic                     clear_done,
  output logic [address_width-1:0] ram_address,
  output logic [data_width-1:0]    ram_data,
  output logic                     ram_wren,
  input  logic [data_width-1:0]    ram_q
);

  state_t                     state, state_next;
  logic [address_width-1:0]   address_next;
  logic [data_width-1:0]      data_next;
  logic                       wren_next;
  logic [1:0]                 ack, ack_next;
  logic                       busy_next;
  logic                       done_next;
  logic                       pending, pending_next;
  logic                       grant, grant_next;
  logic                       last_grant, last_grant_next;
  logic                       pick_valid;
  logic                       pick_grant;

  rr_pick2 u_pick (
    .req_0      (req_0),
    .req_1      (req_1),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  assign ack_0 = ack[REQ_0];
  assign ack_1 = ack[REQ_1];
  assign rdata = ram_q;

  always_comb begin
    state_next      = state;
    address_next    = ram_address;
    data_next       = ram_data;
    wren_next       = ram_wren;
    ack_next        = '0;
    busy_next       = clear_busy;
    done_next       = 1'b0;
    pending_next    = pending | clear_start;
    grant_next      = grant;
    last_grant_next = last_grant;

    unique case (state)
      IDLE: begin
        // A same-cycle clear_start counts as pending so the clear starts on this edge.
        if (pending || clear_start) begin
          state_next   = CLEAR;
          address_next = '0;
          data_next    = clear_value;
          wren_next    = 1'b1;
          busy_next    = 1'b1;
          pending_next = 1'b0;
        end else if (pick_valid) begin
          state_next      = BUSY;
          grant_next      = pick_grant;
          last_grant_next = pick_grant;
          if (pick_grant == REQ_1) begin
            address_next = address_1;
            data_next    = wdata_1;
            wren_next    = wren_1;
          end else begin
            address_next = address_0;
            data_next    = wdata_0;
            wren_next    = wren_0;
          end
        end
      end
      BUSY: begin
        state_next      = DONE;
        wren_next       = 1'b0;
        ack_next[grant] = 1'b1;
      end
      DONE: begin
        state_next = IDLE;
      end
      CLEAR: begin
        pending_next = pending;
        if (ram_address == '1) begin
          state_next = IDLE;
          wren_next  = 1'b0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          address_next = ram_address + address_width'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      ack         <= '0;
      clear_busy  <= 1'b0;
      clear_done  <= 1'b0;
      pending     <= 1'b0;
      grant       <= REQ_0;
      last_grant  <= REQ_1;
    end else begin
      state       <= state_next;
      ram_address <= address_next;
      ram_data    <= data_next;
      ram_wren    <= wren_next;
      ack         <= ack_next;
      clear_busy  <= busy_next;
      clear_done  <= done_next;
      pending     <= pending_next;
      grant       <= grant_next;
      last_grant  <= last_grant_next;
    end
  end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Scoreboard bench for dpram_arbiter with a write-through RAM model on the shared port.
module tb_dpram_arbiter;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_0, req_1, wren_0, wren_1;
  logic [AW-1:0] address_0, address_1;
  logic [DW-1:0] wdata_0, wdata_1;
  logic          ack_0, ack_1;
  logic [DW-1:0] rdata;
  logic          clear_start;
  logic [DW-1:0] clear_value;
  logic          clear_busy, clear_done;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  always #5 clock = ~clock;

  dpram_arbiter #(.address_width(AW), .data_width(DW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_0       (req_0),
    .req_1       (req_1),
    .wren_0      (wren_0),
    .wren_1      (wren_1),
    .address_0   (address_0),
    .address_1   (address_1),
    .wdata_0     (wdata_0),
    .wdata_1     (wdata_1),
    .ack_0       (ack_0),
    .ack_1       (ack_1),
    .rdata       (rdata),
    .clear_start (clear_start),
    .clear_value (clear_value),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= ram_wren ? ram_data : mem[ram_address];
  end

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];
  int            ack_order[$];
  int            ack_cnt0 = 0;
  int            ack_cnt1 = 0;
  int            done_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (clear_done) done_cnt++;
      if (ack_0) begin
        ack_cnt0++;
        ack_order.push_back(0);
        check_eq("ack0_expected", exp0.size() > 0, 1);
        if (exp0.size() > 0) check_eq("rdata0", rdata, exp0.pop_front());
      end
      if (ack_1) begin
        ack_cnt1++;
        ack_order.push_back(1);
        check_eq("ack1_expected", exp1.size() > 0, 1);
        if (exp1.size() > 0) check_eq("rdata1", rdata, exp1.pop_front());
      end
      if (ack_0 || ack_1) begin
        check_eq("ack_onehot", ack_0 & ack_1, 0);
        check_eq("ack_while_clear", clear_busy, 0);
      end
    end
  end

  task automatic req_access(input int id, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic chk_lat);
    int lat  = 0;
    int wcyc = 0;
    logic got = 1'b0;
    if (id == 0) begin
      wren_0 = wr; address_0 = a; wdata_0 = d; req_0 = 1'b1;
      exp0.push_back(wr ? d : ref_mem[a]);
    end else begin
      wren_1 = wr; address_1 = a; wdata_1 = d; req_1 = 1'b1;
      exp1.push_back(wr ? d : ref_mem[a]);
    end
    if (wr) ref_mem[a] = d;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clock);
      lat++;
      if (ram_wren) wcyc++;
      got = (id == 0) ? ack_0 : ack_1;
    end
    check_eq("ack_seen", got, 1);
    if (chk_lat) check_eq("ack_latency", lat, 3);
    if (chk_lat && wr) check_eq("wren_cycles", wcyc, 1);
    @(posedge clock);
    #1;
    if (id == 0) req_0 = 1'b0;
    else         req_1 = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_ram_address", ram_address, 0);
    check_eq("rst_ram_data", ram_data, 0);
    check_eq("rst_ram_wren", ram_wren, 0);
    check_eq("rst_ack_0", ack_0, 0);
    check_eq("rst_ack_1", ack_1, 0);
    check_eq("rst_clear_busy", clear_busy, 0);
    check_eq("rst_clear_done", clear_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int a0;
    int d0;
    logic hit;

    reset_n = 1'b0;
    req_0 = 1'b0; req_1 = 1'b0; wren_0 = 1'b0; wren_1 = 1'b0;
    address_0 = '0; address_1 = '0; wdata_0 = '0; wdata_1 = '0;
    clear_start = 1'b0; clear_value = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = DW'(i * 17);
      ref_mem[i] = DW'(i * 17);
    end
    mem[5]     = 8'hA5;
    ref_mem[5] = 8'hA5;

    #12;
    check_reset_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // single read, requester 1 must stay silent
    req_access(0, 1'b0, 4'h5, 8'h00, 1'b1);
    check_eq("ack1_idle", ack_cnt1, 0);

    // write then read back at the top address
    req_access(1, 1'b1, 4'hF, 8'h3C, 1'b1);
    req_access(1, 1'b0, 4'hF, 8'h00, 1'b1);

    // held tie: last grant was 1, so 0 leads and grants alternate
    ack_order.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) req_access(0, 1'b0, 4'(i), 8'h00, 1'b0);
      end
      begin
        for (int i = 0; i < 4; i++) req_access(1, 1'b0, 4'(i + 8), 8'h00, 1'b0);
      end
    join
    check_eq("tie_count", ack_order.size(), 8);
    for (int i = 0; i < 8 && i < ack_order.size(); i++)
      check_eq("grant_order", ack_order[i], i % 2);

    // full clear
    @(posedge clock);
    #1;
    clear_value = 8'h7E;
    clear_start = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h7E;
    @(posedge clock);
    #1;
    clear_start = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (!clear_busy) break;
      check_eq("clear_addr", ram_address, n);
      check_eq("clear_wren", ram_wren, 1);
      check_eq("clear_data", ram_data, 8'h7E);
      n++;
    end
    check_eq("clear_cycles", n, DEPTH);
    check_eq("clear_done_pulse", clear_done, 1);
    @(negedge clock);
    check_eq("clear_done_once", clear_done, 0);
    @(posedge clock);
    #1;
    req_access(0, 1'b0, 4'h0, 8'h00, 1'b1);
    req_access(1, 1'b0, 4'hF, 8'h00, 1'b1);

    // clear requested while a read is in flight
    req_access(0, 1'b1, 4'h3, 8'h5A, 1'b1);
    a0 = ack_cnt0;
    fork
      req_access(0, 1'b0, 4'h3, 8'h00, 1'b1);
      begin
        @(posedge clock);
        #1;
        clear_value = 8'hC3;
        clear_start = 1'b1;
        @(posedge clock);
        #1;
        clear_start = 1'b0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clock);
          if (clear_busy) break;
        end
        check_eq("busy_rose", clear_busy, 1);
        check_eq("ack0_before_clear", ack_cnt0 - a0, 1);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hC3;
        d0 = done_cnt;
        @(posedge clock);
        #1;
        req_access(1, 1'b0, 4'h9, 8'h00, 1'b0);
        check_eq("ack1_after_done", done_cnt - d0, 1);
      end
    join

    // reset while the clear is at address 7
    @(posedge clock);
    #1;
    clear_value = 8'h11;
    clear_start = 1'b1;
    @(posedge clock);
    #1;
    clear_start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clock);
      hit = clear_busy && (ram_address == 4'h7);
    end
    check_eq("reached_addr7", hit, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    req_access(0, 1'b0, 4'hC, 8'h00, 1'b1);

    repeat (3) @(posedge clock);
    check_eq("queue0_drained", exp0.size(), 0);
    check_eq("queue1_drained", exp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
